uart_fifo_io: RTL
=================

UART_FIFO_IO -- requirements
Module: uart_fifo_io

Interface
REQ-001 SHALL have parameter CLK_DIV, default 868, clock cycles per UART bit, legal range 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, entries per TX and RX FIFO, power of two, legal range 2..256.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port addr  input  2  register select: 0 TXDATA, 1 RXDATA, 2 STATUS, 3 CTRL.
REQ-006 SHALL have port wdata  input  32  write data.
REQ-007 SHALL have port wen  input  1  register write strobe, one cycle per access.
REQ-008 SHALL have port ren  input  1  register read strobe, one cycle per access.
REQ-009 SHALL have port rdata  output  32  read data, registered.
REQ-010 SHALL have port rx  input  1  asynchronous serial input, idle high.
REQ-011 SHALL have port tx  output  1  serial output, idle high.
REQ-012 SHALL have port irq  output  1  level interrupt, registered.

Function
REQ-013 Frame format SHALL be 8N1: start bit low, 8 data bits LSB first, stop bit high, each bit CLK_DIV cycles.
REQ-014 Register map SHALL be as follows.
- TXDATA write: pushes wdata[7:0] into the TX FIFO.
- RXDATA read: pops the RX FIFO.
- STATUS read: [0] rx_nonempty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] overrun (sticky), [5] frame_err (sticky), [6] tx_busy, [15:8] rx_count.
- CTRL read/write: [0] rx_en, [1] tx_en, [2] rx_ie, [3] txe_ie.
- CTRL write side-effects: wdata[4]=1 clears both sticky bits; wdata[5]=1 empties both FIFOs.
REQ-015 Read latency SHALL be exactly one cycle: rdata updates on the cycle after ren and holds until the next ren; unused bits read 0.
REQ-016 RXDATA read with RX FIFO empty SHALL return 0 and SHALL NOT change FIFO state.
REQ-017 TXDATA write with TX FIFO full SHALL be silently dropped, unless the transmitter pops in the same cycle, in which case the write is accepted.
REQ-018 Writes to RXDATA and STATUS, and reads of TXDATA, SHALL have no effect and return 0 where applicable.
REQ-019 TX FSM SHALL have states IDLE, START, DATA, STOP.
- IDLE -> START when tx_en=1 and the TX FIFO is non-empty; the byte is popped at this transition.
- Each state lasts CLK_DIV cycles, DATA lasting 8*CLK_DIV.
- STOP -> START directly when another byte is available, so back-to-back frames have no gap.
REQ-020 tx_en cleared mid-frame SHALL let the current frame finish; no new frame starts.
REQ-021 rx SHALL pass through a 2-flop synchroniser before use.
REQ-022 RX FSM SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE -> START on a synchronised falling edge while rx_en=1.
- START samples at CLK_DIV/2 (integer division); if high, return to IDLE (glitch reject).
- DATA samples every CLK_DIV cycles thereafter; STOP samples once.
REQ-023 Stop sample high SHALL push the byte into the RX FIFO. If the FIFO is full and no pop occurs that cycle, the byte SHALL be discarded and overrun set.
REQ-024 Stop sample low SHALL discard the byte, set frame_err, and enter WAIT_HIGH until the synchronised rx is high, then IDLE.
REQ-025 Each FIFO count SHALL be updated as count + push - pop in the same cycle; simultaneous push and pop at any fill level SHALL leave the count unchanged with data order preserved.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; rx_count SHALL saturate at 255 in STATUS.
REQ-027 irq SHALL be registered as (rx_ie AND rx_nonempty) OR (txe_ie AND tx_empty AND NOT tx_busy).
REQ-028 A flush via CTRL[5] SHALL NOT abort a frame in progress; a flush and a push in the same cycle SHALL leave the FIFO empty.

Reset
REQ-029 On rst SHALL set: tx=1, rdata=0, irq=0, both FIFOs empty, both FSMs IDLE, all counters 0, sticky bits 0, CTRL=0x3.
REQ-030 rst asserted mid-frame SHALL abort the frame; tx SHALL be 1 on the cycle after the reset edge, and no partial byte SHALL be pushed.

Verification (CLK_DIV=4, FIFO_DEPTH=4)
REQ-031 Write TXDATA 0xA5 -> tx low for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high; tx_busy=0 after 40 cycles.
REQ-032 Write 5 bytes to TXDATA in consecutive cycles with tx_en=0, then set tx_en -> 4 frames sent back-to-back with no idle gap, 5th byte dropped.
REQ-033 Drive frame 0x3C on rx, then read RXDATA -> rdata=0x0000003C one cycle after ren, STATUS[0]=0 afterwards.
REQ-034 Drive 5 frames without reading -> rx_count=4, overrun=1; reads return the first 4 bytes in order; CTRL write 0x13 clears overrun.
REQ-035 Drive a frame with stop bit low -> frame_err=1, FIFO unchanged; a 1-cycle low glitch on rx -> no push, no error.
REQ-036 Assert rst in the middle of the DATA state of a TX frame -> tx=1 next cycle, STATUS reads 0x4, irq=0.

Source files
------------

// File: rtl/uart_fifo_io.sv
// Register-mapped 8N1 UART with TX and RX FIFOs, level interrupt and a
// 2-flop synchronised receive input.
module uart_fifo_io #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic        wen,
  input  logic        ren,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [15:0]   DIV_M1   = 16'(CLK_DIV - 1);
  localparam logic [15:0]   HALF_M1  = 16'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  logic [3:0]    r_ctrl;
  logic          r_overrun, r_frame_err;
  logic [7:0]    r_tx_mem [FIFO_DEPTH];
  logic [PW-1:0] r_tx_wp, r_tx_rp;
  logic [CW-1:0] r_tx_cnt;
  logic [7:0]    r_rx_mem [FIFO_DEPTH];
  logic [PW-1:0] r_rx_wp, r_rx_rp;
  logic [CW-1:0] r_rx_cnt;
  tx_state_t     r_tx_state, w_tx_state_n;
  logic [15:0]   r_tx_div;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift, w_tx_shift_n;
  logic          r_tx;
  rx_state_t     r_rx_state, w_rx_state_n;
  logic [15:0]   r_rx_div;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic          r_rx_s1, r_rx_s2, r_rx_d;
  logic [31:0]   r_rdata;
  logic          r_irq;

  logic w_wr_tx, w_wr_ctrl, w_rd_rx, w_flush, w_clr_sticky;
  logic w_tx_en, w_rx_en;
  logic w_tx_empty, w_tx_full, w_tx_push, w_tx_pop, w_tx_tick, w_tx_busy;
  logic w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_rx_push_req;
  logic w_rx_sample, w_frame_err_set, w_overrun_set;
  logic [8:0]  w_rx_cnt9;
  logic [7:0]  w_rx_cnt8;
  logic [31:0] w_status;
  logic        w_unused_wdata;

  assign w_wr_tx      = wen && (addr == 2'd0);
  assign w_wr_ctrl    = wen && (addr == 2'd3);
  assign w_rd_rx      = ren && (addr == 2'd1);
  assign w_flush      = w_wr_ctrl && wdata[5];
  assign w_clr_sticky = w_wr_ctrl && wdata[4];
  assign w_rx_en      = r_ctrl[0];
  assign w_tx_en      = r_ctrl[1];
  assign w_unused_wdata = ^wdata[31:8];

  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == FULL_CNT);
  assign w_tx_push  = w_wr_tx && (!w_tx_full || w_tx_pop);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == FULL_CNT);
  assign w_rx_pop   = w_rd_rx && !w_rx_empty;
  assign w_rx_push  = w_rx_push_req && (!w_rx_full || w_rx_pop);
  assign w_overrun_set = w_rx_push_req && w_rx_full && !w_rx_pop;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= wdata[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_shift;
  end

  // Flush wins over a same-cycle push so the FIFO ends up empty
  always_ff @(posedge clk) begin
    if (rst || w_flush) begin
      r_tx_wp <= '0; r_tx_rp <= '0; r_tx_cnt <= '0;
      r_rx_wp <= '0; r_rx_rp <= '0; r_rx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
      else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - 1'b1;
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
      else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - 1'b1;
    end
  end

  assign w_tx_tick = (r_tx_div == DIV_M1);
  assign w_tx_busy = (r_tx_state != TX_IDLE);

  always_comb begin
    w_tx_state_n = r_tx_state;
    w_tx_pop     = 1'b0;
    w_tx_shift_n = r_tx_shift;
    case (r_tx_state)
      TX_IDLE:  if (w_tx_en && !w_tx_empty) begin
                  w_tx_state_n = TX_START;
                  w_tx_pop     = 1'b1;
                end
      TX_START: if (w_tx_tick) w_tx_state_n = TX_DATA;
      TX_DATA:  if (w_tx_tick) begin
                  if (r_tx_bit == 3'd7) w_tx_state_n = TX_STOP;
                  else w_tx_shift_n = {1'b0, r_tx_shift[7:1]};
                end
      TX_STOP:  if (w_tx_tick) begin
                  if (w_tx_en && !w_tx_empty) begin
                    w_tx_state_n = TX_START;
                    w_tx_pop     = 1'b1;
                  end else begin
                    w_tx_state_n = TX_IDLE;
                  end
                end
      default:  w_tx_state_n = TX_IDLE;
    endcase
    if (w_tx_pop) w_tx_shift_n = r_tx_mem[r_tx_rp];
  end

  // tx is registered from the next state so it lines up with the state change
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_div   <= '0;
      r_tx_bit   <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_n;
      r_tx_div   <= (r_tx_state == TX_IDLE || w_tx_tick) ? 16'd0 : r_tx_div + 16'd1;
      if (r_tx_state != TX_DATA) r_tx_bit <= '0;
      else if (w_tx_tick)        r_tx_bit <= r_tx_bit + 3'd1;
      case (w_tx_state_n)
        TX_START: r_tx <= 1'b0;
        TX_DATA:  r_tx <= w_tx_shift_n[0];
        default:  r_tx <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) r_tx_shift <= w_tx_shift_n;

  always_comb begin
    w_rx_state_n    = r_rx_state;
    w_rx_push_req   = 1'b0;
    w_frame_err_set = 1'b0;
    w_rx_sample     = 1'b0;
    case (r_rx_state)
      RX_IDLE:      if (w_rx_en && !r_rx_s2 && r_rx_d) w_rx_state_n = RX_START;
      RX_START:     if (r_rx_div == HALF_M1) w_rx_state_n = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:      if (r_rx_div == DIV_M1) begin
                      w_rx_sample = 1'b1;
                      if (r_rx_bit == 3'd7) w_rx_state_n = RX_STOP;
                    end
      RX_STOP:      if (r_rx_div == DIV_M1) begin
                      if (r_rx_s2) begin
                        w_rx_push_req = 1'b1;
                        w_rx_state_n  = RX_IDLE;
                      end else begin
                        w_frame_err_set = 1'b1;
                        w_rx_state_n    = RX_WAIT_HIGH;
                      end
                    end
      RX_WAIT_HIGH: if (r_rx_s2) w_rx_state_n = RX_IDLE;
      default:      w_rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_d     <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_div   <= '0;
      r_rx_bit   <= '0;
    end else begin
      r_rx_s1    <= rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_d     <= r_rx_s2;
      r_rx_state <= w_rx_state_n;
      r_rx_div   <= (w_rx_state_n != r_rx_state || w_rx_sample || r_rx_state == RX_IDLE)
                    ? 16'd0 : r_rx_div + 16'd1;
      if (r_rx_state != RX_DATA) r_rx_bit <= '0;
      else if (w_rx_sample)      r_rx_bit <= r_rx_bit + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rx_sample) r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
  end

  assign w_rx_cnt9 = 9'(r_rx_cnt);
  assign w_rx_cnt8 = w_rx_cnt9[8] ? 8'hFF : w_rx_cnt9[7:0];
  assign w_status  = {16'h0, w_rx_cnt8, 1'b0, w_tx_busy, r_frame_err, r_overrun,
                      w_tx_full, w_tx_empty, w_rx_full, !w_rx_empty};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl      <= 4'h3;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_rdata     <= '0;
      r_irq       <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= wdata[3:0];
      if (w_clr_sticky) begin
        r_overrun   <= 1'b0;
        r_frame_err <= 1'b0;
      end
      if (w_overrun_set)   r_overrun   <= 1'b1;
      if (w_frame_err_set) r_frame_err <= 1'b1;
      if (ren) begin
        case (addr)
          2'd1:    r_rdata <= w_rx_empty ? 32'h0 : {24'h0, r_rx_mem[r_rx_rp]};
          2'd2:    r_rdata <= w_status;
          2'd3:    r_rdata <= {28'h0, r_ctrl};
          default: r_rdata <= 32'h0;
        endcase
      end
      r_irq <= (r_ctrl[2] && !w_rx_empty) || (r_ctrl[3] && w_tx_empty && !w_tx_busy);
    end
  end

  assign rdata = r_rdata;
  assign tx    = r_tx;
  assign irq   = r_irq;

endmodule
